// File: rtl/mio_pkg.sv
// Shared definitions for the memory-mapped I/O responder.
// Region codes, timer offsets, FSM states and the unmapped read value.
package mio_pkg;

  localparam logic [3:0] RGN_RAM   = 4'h0;
  localparam logic [3:0] RGN_GPIO  = 4'hE;
  localparam logic [3:0] RGN_TIMER = 4'hF;

  localparam logic [27:0] TMR_CNT_OFS = 28'h0;
  localparam logic [27:0] TMR_ACK_OFS = 28'h4;

  localparam logic [31:0] UNMAPPED_RD = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RG_RAM,
    RG_GPIO,
    RG_TMR,
    RG_NONE
  } region_t;

  function automatic region_t decode_region(input logic [3:0] code);
    region_t r;
    unique case (code)
      RGN_RAM:   r = RG_RAM;
      RGN_GPIO:  r = RG_GPIO;
      RGN_TIMER: r = RG_TMR;
      default:   r = RG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// Reloading down-counter with a sticky interrupt.
// Ports: clk, reset, load/load_val (set count+reload), ack (clear irq), count, irq.
module mio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        ack,
  output logic [31:0] count,
  output logic        irq
);

  logic [31:0] reload;
  logic        fire;

  // A load suppresses the decrement, so it also suppresses the 1->0 fire.
  assign fire = !load && (count == 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      reload <= '0;
      irq    <= 1'b0;
    end else begin
      if (load) begin
        count  <= load_val;
        reload <= load_val;
      end else if (count != 32'd0) begin
        count <= fire ? reload : count - 32'd1;
      end
      // Set wins over a simultaneous acknowledge.
      if (fire)
        irq <= 1'b1;
      else if (ack)
        irq <= 1'b0;
    end
  end

endmodule

// File: rtl/mio_responder.sv
// MIO bus responder: word RAM, GPIO (SW/LED) and timer with wait states.
// Ports: CPU request (CPU_MIO/mem_w/Addr_out/Data_out), Data_in/MIO_ready/bus_err, INT, SW, LED.
module mio_responder
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        INT,
  input  logic [15:0] SW,
  output logic [15:0] LED,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  wcnt;
  logic [31:0] addr_q, data_q;
  logic        w_q;

  logic [31:0] addr_e, data_e;
  logic        w_e;
  logic        latch, go_resp;
  region_t     rg;
  logic [27:0] ofs;
  logic [AW-1:0] idx;
  logic [31:0] rd_val;

  logic [31:0] ram [RAM_WORDS];

  logic        tmr_load, tmr_ack;
  logic [31:0] tmr_count;

  // With no wait states the access happens on the sampling edge,
  // before the latches are loaded, so use the live bus then.
  assign addr_e = (state == S_IDLE) ? Addr_out : addr_q;
  assign data_e = (state == S_IDLE) ? Data_out : data_q;
  assign w_e    = (state == S_IDLE) ? mem_w    : w_q;

  assign rg  = decode_region(addr_e[31:28]);
  assign ofs = addr_e[27:0];
  assign idx = addr_e[AW+1:2];

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    go_resp   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (CPU_MIO) begin
          latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_RESP;
            go_resp   = 1'b1;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wcnt <= 4'd1) begin
          state_nxt = S_RESP;
          go_resp   = 1'b1;
        end
      end
      S_RESP: state_nxt = S_DONE;
      S_DONE: if (!CPU_MIO) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rd_val = UNMAPPED_RD;
    unique case (1'b1)
      rg == RG_RAM:  rd_val = ram[idx];
      rg == RG_GPIO: rd_val = {16'h0, SW};
      rg == RG_TMR: begin
        if (ofs == TMR_CNT_OFS)
          rd_val = tmr_count;
        else if (ofs == TMR_ACK_OFS)
          rd_val = {31'h0, INT};
      end
      default: rd_val = UNMAPPED_RD;
    endcase
  end

  assign tmr_load = go_resp && w_e && rg == RG_TMR
                    && ofs == TMR_CNT_OFS;
  assign tmr_ack  = go_resp && w_e && rg == RG_TMR
                    && ofs == TMR_ACK_OFS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      w_q       <= 1'b0;
      Data_in   <= '0;
      MIO_ready <= 1'b0;
      bus_err   <= 1'b0;
      LED       <= '0;
    end else begin
      state <= state_nxt;
      if (latch) begin
        addr_q <= Addr_out;
        data_q <= Data_out;
        w_q    <= mem_w;
        wcnt   <= WAIT_INIT;
      end else if (state == S_WAIT && wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
      MIO_ready <= go_resp;
      bus_err   <= go_resp && rg == RG_NONE;
      if (go_resp && !w_e)
        Data_in <= rd_val;
      if (go_resp && w_e && rg == RG_GPIO)
        LED <= data_e[15:0];
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (go_resp && w_e && rg == RG_RAM)
      ram[idx] <= data_e;
  end

  mio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (data_e),
    .ack      (tmr_ack),
    .count    (tmr_count),
    .irq      (INT)
  );

endmodule

// File: tb/tb_mio_responder.sv
// Randomized scoreboard bench for mio_responder.
// Main instance uses 2 wait states; a second instance covers zero wait states.
module tb_mio_responder;

  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CPU_MIO = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] Addr_out = '0;
  logic [31:0] Data_out = '0;
  logic [15:0] SW = '0;
  logic [31:0] Data_in;
  logic        MIO_ready;
  logic        INT;
  logic [15:0] LED;
  logic        bus_err;

  logic        CPU_MIO_z = 1'b0;
  logic        mem_w_z = 1'b0;
  logic [31:0] Addr_out_z = '0;
  logic [31:0] Data_out_z = '0;
  logic [31:0] Data_in_z;
  logic        MIO_ready_z;
  logic        INT_z;
  logic [15:0] LED_z;
  logic        bus_err_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mio_responder #(.WAIT_CYCLES(WAITC), .RAM_WORDS(256)) u_dut (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
    .Addr_out(Addr_out), .Data_out(Data_out), .Data_in(Data_in),
    .MIO_ready(MIO_ready), .INT(INT), .SW(SW), .LED(LED),
    .bus_err(bus_err)
  );

  mio_responder #(.WAIT_CYCLES(0), .RAM_WORDS(256)) u_dut0 (
    .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO_z), .mem_w(mem_w_z),
    .Addr_out(Addr_out_z), .Data_out(Data_out_z), .Data_in(Data_in_z),
    .MIO_ready(MIO_ready_z), .INT(INT_z), .SW(16'h1234), .LED(LED_z),
    .bus_err(bus_err_z)
  );

  // Reference model state
  logic [31:0] m_ram [int];
  logic [15:0] m_led = '0;
  logic [31:0] m_cnt = '0, m_rel = '0, m_din = '0;
  logic        m_int = 1'b0;

  bit          op_pend = 0;
  int          op_delay = 0;
  bit          op_w;
  logic [31:0] op_addr, op_data;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int  wr_idx[$];
  bit  mon_on = 0;

  task automatic model_step();
    logic [31:0] rd;
    logic [27:0] of;
    bit err, ld, ak, fire;
    rd = m_din; err = 0; ld = 0; ak = 0;
    if (op_pend) begin
      op_delay--;
      if (op_delay == 0) begin
        op_pend = 0;
        of = op_addr[27:0];
        case (op_addr[31:28])
          4'h0: begin
            if (op_w) m_ram[int'(op_addr[9:2])] = op_data;
            else rd = m_ram[int'(op_addr[9:2])];
          end
          4'hE: begin
            if (op_w) m_led = op_data[15:0];
            else rd = {16'h0, SW};
          end
          4'hF: begin
            if (of == 28'h0) begin
              if (op_w) ld = 1; else rd = m_cnt;
            end else if (of == 28'h4) begin
              if (op_w) ak = 1; else rd = {31'h0, m_int};
            end else if (!op_w) rd = 32'h0;
          end
          default: begin
            err = 1;
            if (!op_w) rd = 32'h0;
          end
        endcase
        m_din = rd;
        exp_q.push_back('{rd, err});
      end
    end
    fire = !ld && m_cnt == 32'd1;
    if (ld) begin
      m_cnt = op_data; m_rel = op_data;
    end else if (m_cnt != 0) begin
      m_cnt = fire ? m_rel : m_cnt - 1;
    end
    if (fire) m_int = 1;
    else if (ak) m_int = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_led = 0; m_cnt = 0; m_rel = 0; m_int = 0; m_din = 0;
        op_pend = 0; exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    wait (mon_on);
    forever begin
      @(negedge clk);
      checks++;
      if (LED !== m_led || INT !== m_int) begin
        errors++;
        $display("FAIL led_int got %h/%b exp %h/%b", LED, INT, m_led, m_int);
      end
      if (bus_err && !MIO_ready) begin
        errors++;
        $display("FAIL bus_err_alone got 1 exp 0");
      end
      if (MIO_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready got 1 exp 0");
        end else begin
          e = exp_q.pop_front();
          if (Data_in !== e.data || bus_err !== e.err) begin
            errors++;
            $display("FAIL rsp got %h err %b exp %h err %b",
                     Data_in, bus_err, e.data, e.err);
          end
        end
      end
    end
  end

  task automatic do_req(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    int lat;
    bit got;
    CPU_MIO = 1; mem_w = w; Addr_out = a; Data_out = d;
    op_w = w; op_addr = a; op_data = d;
    op_delay = WAITC + 1; op_pend = 1;
    @(posedge clk);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        Addr_out = $urandom; Data_out = $urandom; mem_w = ~w;
      end
      if (MIO_ready) got = 1;
    end
    checks++;
    if (!got || lat != WAITC + 1) begin
      errors++;
      $display("FAIL latency got %0d exp %0d", lat, WAITC + 1);
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 CPU_MIO = 0;
    @(posedge clk); #1;
  endtask

  task automatic do_z(input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] ex,
                      input bit ex_err);
    int lat;
    bit got;
    CPU_MIO_z = 1; mem_w_z = w; Addr_out_z = a; Data_out_z = d;
    @(posedge clk);
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (MIO_ready_z) got = 1;
    end
    checks++;
    if (!got || lat != 1) begin
      errors++;
      $display("FAIL z_latency got %0d exp 1", lat);
    end
    checks++;
    if (bus_err_z !== ex_err || (!w && Data_in_z !== ex)) begin
      errors++;
      $display("FAIL z_rsp got %h err %b exp %h err %b",
               Data_in_z, bus_err_z, ex, ex_err);
    end
    @(posedge clk); #1 CPU_MIO_z = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    int k, x;
    logic [31:0] a;
    logic [7:0] id;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    checks++;
    if (Data_in !== 0 || MIO_ready !== 0 || bus_err !== 0
        || LED !== 0 || INT !== 0) begin
      errors++;
      $display("FAIL reset_state got %h %b %b %h %b exp 0",
               Data_in, MIO_ready, bus_err, LED, INT);
    end
    mon_on = 1;
    @(posedge clk); #1;

    do_req(1, 32'h0000_0010, 32'h1234_5678, 0);
    wr_idx.push_back(4);
    do_req(0, 32'h0000_0010, 32'h0, 0);
    SW = 16'hA5A5;
    do_req(0, 32'hE000_0000, 32'h0, 0);
    do_req(1, 32'hE000_0000, 32'hFFFF_00FF, 0);
    checks++;
    if (LED !== 16'h00FF) begin
      errors++;
      $display("FAIL led_write got %h exp 00ff", LED);
    end
    do_req(0, 32'h3000_0000, 32'h0, 0);
    do_req(1, 32'hF000_0000, 32'd5, 0);
    repeat (12) @(posedge clk); #1;
    do_req(1, 32'hF000_0004, 32'hDEAD, 0);
    repeat (12) @(posedge clk); #1;
    do_req(1, 32'h0000_0020, 32'h0BAD_F00D, 8);
    wr_idx.push_back(8);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      SW = 16'($urandom);
      case (k)
        0, 1: begin
          id = 8'($urandom);
          a = {4'h0, 18'($urandom), id, 2'b00};
          do_req(1, a, $urandom, $urandom_range(0, 2));
          wr_idx.push_back(int'(id));
        end
        2, 3: begin
          x = wr_idx[$urandom_range(0, wr_idx.size() - 1)];
          a = {4'h0, 18'($urandom), 8'(x), 2'b00};
          do_req(0, a, $urandom, $urandom_range(0, 2));
        end
        4: do_req($urandom_range(0, 1), 32'hE000_0000 | 28'($urandom),
                  $urandom, 0);
        5: do_req(1, 32'hF000_0000, $urandom_range(0, 12), 0);
        6: do_req($urandom_range(0, 1), 32'hF000_0004, $urandom, 0);
        7: do_req(0, 32'hF000_0000, 0, 0);
        8: do_req($urandom_range(0, 1),
                  {4'($urandom_range(1, 13)), 28'($urandom)}, $urandom, 0);
        default: begin
          repeat ($urandom_range(1, 6)) @(posedge clk);
          #1;
        end
      endcase
    end

    // Reset during WAIT: the pending LED write must never complete.
    do_req(1, 32'hF000_0000, 32'd3, 0);
    do_req(0, 32'h0000_0010, 32'h0, 0);
    CPU_MIO = 1; mem_w = 1; Addr_out = 32'hE000_0000; Data_out = 32'h0000_BEEF;
    op_w = 1; op_addr = Addr_out; op_data = Data_out;
    op_delay = WAITC + 1; op_pend = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if (MIO_ready !== 0 || LED !== 0 || INT !== 0 || Data_in !== 0) begin
      errors++;
      $display("FAIL mid_reset got %b %h %b %h exp 0", MIO_ready, LED, INT, Data_in);
    end
    CPU_MIO = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (LED !== 0 || Data_in !== 0) begin
      errors++;
      $display("FAIL post_reset got %h %h exp 0", LED, Data_in);
    end
    // RAM survives reset.
    do_req(0, 32'h0000_0010, 32'h0, 0);

    // Zero wait states, back-to-back with one-cycle gaps.
    do_z(1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 0);
    do_z(0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0);
    do_z(1, 32'h0000_0044, 32'h0000_0001, 32'h0, 0);
    do_z(0, 32'h0000_0044, 32'h0, 32'h0000_0001, 0);
    do_z(0, 32'hE000_0000, 32'h0, 32'h0000_1234, 0);
    do_z(0, 32'h5000_0000, 32'h0, 32'h0, 1);

    repeat (4) @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
